// File: rtl/muldiv_pkg.sv
// Shared types and op-decoding helpers for the RV32M multiply/divide sequencer.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } muldiv_state_e;

    function automatic logic is_div(input muldiv_op_e op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic is_rem(input muldiv_op_e op);
        return op inside {OP_REM, OP_REMU};
    endfunction

    function automatic logic is_signed_a(input muldiv_op_e op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic is_signed_b(input muldiv_op_e op);
        return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/muldiv_iter_unit.sv
// Datapath for the iterative multiply/divide: operand magnitudes, one shift-add or
// restoring-subtract step per strobe, sign fixup and the held result register.
module muldiv_iter_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic             fix,
    input  logic             fast_load,
    input  muldiv_op_e       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [WIDTH-1:0] fast_val,
    output logic [WIDTH-1:0] result
);

    // hi/lo form the 2*WIDTH product; for divides hi is the partial remainder
    // and lo shifts the dividend out while the quotient shifts in.
    logic [WIDTH-1:0] hi_q, lo_q, opnd_q;
    muldiv_op_e       op_q;
    logic             neg_a_q, neg_b_q;

    logic             neg_a, neg_b;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             ge;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix, fixed;

    assign neg_a = is_signed_a(op) && src_a[WIDTH-1];
    assign neg_b = is_signed_b(op) && src_b[WIDTH-1];

    assign sum     = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opnd_q : '0)};
    assign shifted = {hi_q, lo_q[WIDTH-1]};
    // A set top bit means shifted >= 2^WIDTH > divisor; otherwise the borrow decides.
    assign diff    = {1'b0, shifted[WIDTH-1:0]} - {1'b0, opnd_q};
    assign ge      = shifted[WIDTH] | ~diff[WIDTH];

    assign prod     = {hi_q, lo_q};
    assign prod_fix = (neg_a_q ^ neg_b_q) ? -prod : prod;
    assign quo_fix  = (neg_a_q ^ neg_b_q) ? -lo_q : lo_q;
    assign rem_fix  = neg_a_q ? -hi_q : hi_q;

    always_comb begin
        fixed = prod_fix[WIDTH-1:0];
        case (op_q)
            OP_MUL:                       fixed = prod_fix[WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fixed = prod_fix[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU:              fixed = quo_fix;
            OP_REM, OP_REMU:              fixed = rem_fix;
            default:                      fixed = prod_fix[WIDTH-1:0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q    <= '0;
            lo_q    <= '0;
            opnd_q  <= '0;
            op_q    <= OP_MUL;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            result  <= '0;
        end else begin
            if (load) begin
                op_q    <= op;
                neg_a_q <= neg_a;
                neg_b_q <= neg_b;
                hi_q    <= '0;
                lo_q    <= neg_a ? -src_a : src_a;
                opnd_q  <= neg_b ? -src_b : src_b;
            end else if (step) begin
                if (is_div(op_q)) begin
                    hi_q <= ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
                    lo_q <= {lo_q[WIDTH-2:0], ge};
                end else begin
                    hi_q <= sum[WIDTH:1];
                    lo_q <= {sum[0], lo_q[WIDTH-1:1]};
                end
            end
            if (fast_load) begin
                result <= fast_val;
            end else if (fix) begin
                result <= fixed;
            end
        end
    end

endmodule

// File: rtl/execute_muldiv_ctrl.sv
// Execute-stage RV32M sequencer: FSM, iteration counter, stall/valid generation and
// the div-by-zero / signed-overflow fast path around the iterative datapath.
module execute_muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             flush_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] srcA_i,
    input  logic [WIDTH-1:0] srcB_i,
    output logic             stall_o,
    output logic             busy_o,
    output logic             result_valid_o,
    output logic [WIDTH-1:0] result_o
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

    muldiv_state_e    state, state_next;
    logic [CNT_W-1:0] count;
    muldiv_op_e       op;
    logic             go, div_zero, ovf, fast;
    logic [WIDTH-1:0] fast_val;
    logic             load, step, fix, fast_load;

    assign op       = muldiv_op_e'(op_i);
    assign go       = start_i && !flush_i;
    assign div_zero = is_div(op) && (srcB_i == '0);
    assign ovf      = (op inside {OP_DIV, OP_REM}) && (srcA_i == MIN_INT) && (srcB_i == '1);
    assign fast     = div_zero || ovf;

    always_comb begin
        fast_val = '0;
        if (div_zero) begin
            fast_val = is_rem(op) ? srcA_i : '1;
        end else if (ovf) begin
            fast_val = is_rem(op) ? '0 : srcA_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_next;
            if (load) begin
                count <= CNT_W'(WIDTH);
            end else if (step) begin
                count <= count - 1'b1;
            end
        end
    end

    // A flush in any state drops stall and valid combinationally and returns to IDLE.
    always_comb begin
        state_next     = state;
        stall_o        = 1'b0;
        result_valid_o = 1'b0;
        load           = 1'b0;
        step           = 1'b0;
        fix            = 1'b0;
        fast_load      = 1'b0;
        case (state)
            IDLE: begin
                if (go) begin
                    stall_o = 1'b1;
                    if (fast) begin
                        fast_load  = 1'b1;
                        state_next = DONE;
                    end else begin
                        load       = 1'b1;
                        state_next = BUSY;
                    end
                end
            end
            BUSY: begin
                if (flush_i) begin
                    state_next = IDLE;
                end else begin
                    stall_o = 1'b1;
                    step    = 1'b1;
                    if (count == CNT_W'(1)) begin
                        state_next = FIXUP;
                    end
                end
            end
            FIXUP: begin
                if (flush_i) begin
                    state_next = IDLE;
                end else begin
                    stall_o    = 1'b1;
                    fix        = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                result_valid_o = !flush_i;
                state_next     = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy_o = (state != IDLE);

    muldiv_iter_unit #(.WIDTH(WIDTH)) u_iter (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .step      (step),
        .fix       (fix),
        .fast_load (fast_load),
        .op        (op),
        .src_a     (srcA_i),
        .src_b     (srcB_i),
        .fast_val  (fast_val),
        .result    (result_o)
    );

endmodule

// File: tb/tb_execute_muldiv_ctrl.sv
// Directed-vector bench for execute_muldiv_ctrl with hand-computed RV32M results.
module tb_execute_muldiv_ctrl;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         flush;
    logic [2:0]   op;
    logic [W-1:0] a, b;
    logic         stall, busy, valid;
    logic [W-1:0] result;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    execute_muldiv_ctrl #(.WIDTH(W)) dut (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start),
        .flush_i        (flush),
        .op_i           (op),
        .srcA_i         (a),
        .srcB_i         (b),
        .stall_o        (stall),
        .busy_o         (busy),
        .result_valid_o (valid),
        .result_o       (result)
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issues one op and follows it to its single valid cycle at 'lat'.
    // With keep set it returns inside DONE so the caller can issue back-to-back.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input logic [W-1:0] exp, input int lat,
                          input bit keep);
        int stall_cnt;
        int early_valid;
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        if (busy) tick;
        else #1;
        check({tag, ".stall_c0"}, W'(stall), W'(1));
        stall_cnt   = 1;
        early_valid = 0;
        for (int c = 1; c <= lat; c++) begin
            tick;
            if (c < lat) begin
                stall_cnt   += int'(stall);
                early_valid += int'(valid);
            end
        end
        check({tag, ".valid"}, W'(valid), W'(1));
        check({tag, ".stall_done"}, W'(stall), W'(0));
        check({tag, ".result"}, result, exp);
        check({tag, ".stall_cycles"}, W'(stall_cnt), W'(lat));
        check({tag, ".early_valid"}, W'(early_valid), W'(0));
        if (!keep) begin
            start = 1'b0;
            tick;
            check({tag, ".valid_after"}, W'(valid), W'(0));
            check({tag, ".busy_after"}, W'(busy), W'(0));
        end
    endtask

    initial begin
        int vcnt;
        rst   = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        op    = 3'b000;
        a     = '0;
        b     = '0;
        repeat (3) tick;
        check("rst.stall", W'(stall), W'(0));
        check("rst.busy", W'(busy), W'(0));
        check("rst.valid", W'(valid), W'(0));
        check("rst.result", result, 32'h0);
        rst = 1'b0;
        tick;

        // Multiplies
        run_op("mul_neg",    3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 1'b0);
        run_op("mulhu_max",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 1'b0);
        run_op("mulh_m1",    3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34, 1'b0);
        run_op("mulhsu",     3'b010, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 34, 1'b0);

        // Divides
        run_op("div_neg",    3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34, 1'b0);
        run_op("rem_neg",    3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34, 1'b0);
        run_op("divu",       3'b101, 32'd100,       32'd7,         32'd14,        34, 1'b0);
        run_op("remu",       3'b111, 32'd100,       32'd7,         32'd2,         34, 1'b0);

        // Fast path
        run_op("divu_zero",  3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1, 1'b0);
        run_op("remu_zero",  3'b111, 32'd9,         32'd0,         32'd9,         1, 1'b0);
        run_op("rem_ovf",    3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1, 1'b0);
        run_op("div_ovf",    3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b0);

        // Flush at cycle 10 of a DIV
        start = 1'b1;
        op    = 3'b100;
        a     = 32'd100;
        b     = 32'd7;
        #1;
        for (int c = 1; c <= 10; c++) tick;
        check("flush.busy_c10", W'(busy), W'(1));
        flush = 1'b1;
        #1;
        check("flush.stall_c10", W'(stall), W'(0));
        check("flush.valid_c10", W'(valid), W'(0));
        tick;
        start = 1'b0;
        flush = 1'b0;
        #1;
        check("flush.busy_c11", W'(busy), W'(0));
        vcnt = 0;
        for (int c = 0; c < 40; c++) begin
            tick;
            vcnt += int'(valid);
        end
        check("flush.no_valid", W'(vcnt), W'(0));
        run_op("mul_after_flush", 3'b000, 32'd3, 32'd4, 32'd12, 34, 1'b0);

        // Reset mid-operation
        start = 1'b1;
        op    = 3'b000;
        a     = 32'd5;
        b     = 32'd6;
        #1;
        for (int c = 1; c <= 5; c++) tick;
        rst   = 1'b1;
        start = 1'b0;
        tick;
        check("midrst.stall", W'(stall), W'(0));
        check("midrst.busy", W'(busy), W'(0));
        check("midrst.valid", W'(valid), W'(0));
        check("midrst.result", result, 32'h0);
        rst = 1'b0;
        tick;

        // Back-to-back issue: the DIV is presented during the MUL's DONE cycle
        run_op("b2b_mul",  3'b000, 32'd6,   32'd7, 32'd42, 34, 1'b1);
        run_op("b2b_divu", 3'b101, 32'd100, 32'd7, 32'd14, 34, 1'b0);
        vcnt = 0;
        for (int c = 0; c < 40; c++) begin
            tick;
            vcnt += int'(valid);
        end
        check("b2b.no_dup", W'(vcnt), W'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
